// File: rtl/adc_axis_pkg.sv
// Shared types and elaboration helpers for the ADC-to-AXI-Stream packer.
package adc_axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int frame_w(input int num_ch, input int sample_w);
    return num_ch * sample_w;
  endfunction

  function automatic int beats(input int num_ch, input int sample_w, input int axis_w);
    return (num_ch * sample_w) / axis_w;
  endfunction

  // Never returns less than 1 so it can size a counter directly.
  function automatic int clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: array storage plus a registered output stage,
// so a word written at edge E is presented after edge E+1.
module sync_fifo_fwft
  import adc_axis_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] out_q;
  logic             out_vld;
  logic             wr_ok, load;

  assign full    = (count == (AW+1)'(DEPTH));
  assign wr_ok   = wr_en && !full;
  assign load    = (count != '0) && (!out_vld || rd_en);
  assign empty   = !out_vld;
  assign rd_data = out_vld ? out_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out_vld <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (load)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, load};
      if (load)       out_vld <= 1'b1;
      else if (rd_en) out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
    if (load)  out_q <= mem[rd_ptr];
  end

endmodule

// File: rtl/adc_axis_packer.sv
// Captures sample_len ADC frames and serialises them into AXI-Stream beats.
// Define ADC_PACKER_TEST_PATTERN_EN to replace captured data with a counter.
module adc_axis_packer
  import adc_axis_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 16,
  parameter int AXIS_W     = 8,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                                  adc_clk,
  input  logic                                  adc_rst_n,
  input  logic [31:0]                           sample_len,
  input  logic                                  sample_start,
  output logic                                  sample_en,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow,
  input  logic                                  s_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]            s_data,
  output logic [AXIS_W-1:0]                     m_axis_tdata,
  output logic [((AXIS_W/8 < 1) ? 1 : AXIS_W/8)-1:0] m_axis_tkeep,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast
);

  localparam int FRAME_W = frame_w(NUM_CH, SAMPLE_W);
  localparam int BEATS   = beats(NUM_CH, SAMPLE_W, AXIS_W);
  localparam int IDX_W   = clog2(BEATS);

  if ((FRAME_W % AXIS_W) != 0) begin : g_bad_axis_w
    $error("NUM_CH*SAMPLE_W must be an integer multiple of AXIS_W");
  end

  state_t             state;
  logic [31:0]        len_q, frame_cnt;
  logic [FRAME_W-1:0] ser_data, frame_in;
  logic [IDX_W-1:0]   ser_idx;
  logic               ser_busy, ser_last;
  logic               fifo_full, fifo_empty, push, beat_last, ser_free;
  logic               capture, drop, last_frame, pop;
  logic [AXIS_W:0]    fifo_dout;

`ifdef ADC_PACKER_TEST_PATTERN_EN
  logic unused_s_data;
  assign unused_s_data = ^s_data;
  always_comb begin
    frame_in = '0;
    for (int c = 0; c < NUM_CH; c++)
      frame_in[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(frame_cnt * NUM_CH + c);
  end
`else
  assign frame_in = s_data;
`endif

  // The serialiser counts as free in the cycle its final beat leaves, so
  // frames spaced exactly BEATS cycles apart stream back-to-back.
  assign beat_last  = (ser_idx == IDX_W'(BEATS - 1));
  assign push       = ser_busy && !fifo_full;
  assign ser_free   = !ser_busy || (push && beat_last);
  assign capture    = (state == ST_RUN) && s_valid && ser_free;
  assign drop       = (state == ST_RUN) && s_valid && !ser_free;
  assign last_frame = (frame_cnt + 32'd1 == len_q);
  assign pop        = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      frame_cnt <= '0;
      ser_idx   <= '0;
      ser_busy  <= 1'b0;
      ser_last  <= 1'b0;
      sample_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push) begin
        ser_idx <= ser_idx + 1'b1;
        if (beat_last) ser_busy <= 1'b0;
      end
      if (capture) begin
        ser_busy  <= 1'b1;
        ser_idx   <= '0;
        ser_last  <= last_frame;
        frame_cnt <= frame_cnt + 32'd1;
      end
      if (drop) overflow <= 1'b1;
      case (state)
        ST_IDLE: if (sample_start && sample_len != 32'd0) begin
          len_q     <= sample_len;
          frame_cnt <= '0;
          ser_idx   <= '0;
          overflow  <= 1'b0;
          sample_en <= 1'b1;
          busy      <= 1'b1;
          state     <= ST_RUN;
        end
        ST_RUN: if (capture && last_frame) begin
          sample_en <= 1'b0;
          state     <= ST_DRAIN;
        end
        ST_DRAIN: if (pop && m_axis_tlast) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk) begin
    if (capture)   ser_data <= frame_in;
    else if (push) ser_data <= ser_data >> AXIS_W;
  end

  sync_fifo_fwft #(
    .WIDTH (AXIS_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (adc_clk),
    .rst_n   (adc_rst_n),
    .wr_en   (push),
    .wr_data ({ser_last && beat_last, ser_data[AXIS_W-1:0]}),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout[AXIS_W-1:0];
  assign m_axis_tlast  = fifo_dout[AXIS_W];
  assign m_axis_tkeep  = '1;

endmodule

// File: tb/tb_adc_axis_packer.sv
// Randomised bench for adc_axis_packer with a frame-level scoreboard model.
module tb_adc_axis_packer;

  localparam int NUM_CH     = 4;
  localparam int SAMPLE_W   = 16;
  localparam int AXIS_W     = 8;
  localparam int FIFO_DEPTH = 512;
  localparam int FRAME_W    = NUM_CH * SAMPLE_W;
  localparam int BEATS      = FRAME_W / AXIS_W;
  localparam int KEEP_W     = (AXIS_W / 8 < 1) ? 1 : AXIS_W / 8;
`ifdef ADC_PACKER_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic               adc_clk = 1'b0;
  logic               adc_rst_n = 1'b0;
  logic [31:0]        sample_len = '0;
  logic               sample_start = 1'b0;
  logic               sample_en, busy, done, overflow;
  logic               s_valid = 1'b0;
  logic [FRAME_W-1:0] s_data = '0;
  logic [AXIS_W-1:0]  m_axis_tdata;
  logic [KEEP_W-1:0]  m_axis_tkeep;
  logic               m_axis_tvalid, m_axis_tlast;
  logic               m_axis_tready = 1'b1;

  always #5 adc_clk = ~adc_clk;

  adc_axis_packer #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .AXIS_W(AXIS_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .sample_len(sample_len),
    .sample_start(sample_start), .sample_en(sample_en), .busy(busy), .done(done),
    .overflow(overflow), .s_valid(s_valid), .s_data(s_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard state: expected beats as {tlast, tdata}
  logic [AXIS_W:0] exp_q[$];
  int  cyc = 0;
  int  beats_seen = 0, tlast_seen = 0, done_cnt = 0;
  int  run_len = 0, run_acc = 0, last_acc_edge = -1000;
  bit  exp_ovf = 1'b0;
  int  run_done0, run_beats0, run_tlast0;
  int  rdy_mode = 0;

  always @(posedge adc_clk) cyc++;

  initial begin
    forever begin
      @(posedge adc_clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        2:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pops, hold-while-stalled and done timing
  logic [AXIS_W:0]   mon_e;
  bit                stall_prev = 1'b0, last_hs_prev = 1'b0;
  logic [AXIS_W-1:0] prev_data;
  logic              prev_last;

  always @(negedge adc_clk) begin
    if (!adc_rst_n) begin
      stall_prev   = 1'b0;
      last_hs_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk_eq("hold_tvalid", m_axis_tvalid, 1'b1);
        chk_eq("hold_tdata", m_axis_tdata, prev_data);
        chk_eq("hold_tlast", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk_eq("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk_eq("tdata", m_axis_tdata, mon_e[AXIS_W-1:0]);
          chk_eq("tlast", m_axis_tlast, mon_e[AXIS_W]);
        end
        beats_seen++;
        if (m_axis_tlast) tlast_seen++;
      end
      if (done) begin
        done_cnt++;
        chk_eq("busy_low_at_done", busy, 1'b0);
        chk_eq("done_after_tlast_hs", last_hs_prev, 1'b1);
      end
      stall_prev   = m_axis_tvalid && !m_axis_tready;
      prev_data    = m_axis_tdata;
      prev_last    = m_axis_tlast;
      last_hs_prev = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge adc_clk);
    #1;
  endtask

  function automatic logic [FRAME_W-1:0] model_frame(input logic [FRAME_W-1:0] d, input int f);
    logic [FRAME_W-1:0] pat;
    pat = '0;
    for (int c = 0; c < NUM_CH; c++)
      pat[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(f * NUM_CH + c);
    return TP ? pat : d;
  endfunction

  task automatic start_run(input int len);
    sample_len   = len;
    sample_start = 1'b1;
    tick();
    sample_start = 1'b0;
    sample_len   = $urandom;
    chk_eq("sample_en_after_start", sample_en, len != 0);
    chk_eq("busy_after_start", busy, len != 0);
    if (len != 0) begin
      chk_eq("overflow_cleared_on_start", overflow, 1'b0);
      run_len = len; run_acc = 0; exp_ovf = 1'b0; last_acc_edge = -1000;
      run_done0 = done_cnt; run_beats0 = beats_seen; run_tlast0 = tlast_seen;
    end
  endtask

  // One-cycle s_valid strobe; the model accepts it only if the previous
  // accepted frame was sampled at least BEATS edges earlier.
  task automatic send_frame(input logic [FRAME_W-1:0] d);
    int samp_edge;
    logic [FRAME_W-1:0] fr;
    samp_edge = cyc + 1;
    s_data  = d;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    s_data  = {$urandom, $urandom};
    if (run_acc < run_len) begin
      if (samp_edge - last_acc_edge >= BEATS) begin
        fr = model_frame(d, run_acc);
        for (int k = 0; k < BEATS; k++)
          exp_q.push_back({(run_acc + 1 == run_len) && (k == BEATS - 1),
                           fr[k*AXIS_W +: AXIS_W]});
        run_acc++;
        last_acc_edge = samp_edge;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic finish_run(input string tag);
    int budget = 3000;
    while (done_cnt == run_done0 && budget > 0) begin
      tick();
      budget--;
    end
    chk_eq({tag, "_done_in_time"}, budget > 0, 1'b1);
    tick(2);
    chk_eq({tag, "_done_once"}, done_cnt - run_done0, 1);
    chk_eq({tag, "_beat_count"}, beats_seen - run_beats0, run_acc * BEATS);
    chk_eq({tag, "_tlast_count"}, tlast_seen - run_tlast0, 1);
    chk_eq({tag, "_scoreboard_empty"}, exp_q.size(), 0);
    chk_eq({tag, "_overflow"}, overflow, exp_ovf);
    chk_eq({tag, "_busy_idle"}, busy, 1'b0);
    chk_eq({tag, "_sample_en_idle"}, sample_en, 1'b0);
    chk_eq({tag, "_tvalid_idle"}, m_axis_tvalid, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    int b0;
    // Reset values
    tick(2);
    chk_eq("rst_sample_en", sample_en, 1'b0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_done", done, 1'b0);
    chk_eq("rst_overflow", overflow, 1'b0);
    chk_eq("rst_tvalid", m_axis_tvalid, 1'b0);
    chk_eq("rst_tlast", m_axis_tlast, 1'b0);
    chk_eq("rst_tdata", m_axis_tdata, 0);
    chk_eq("tkeep_all_ones", m_axis_tkeep, {KEEP_W{1'b1}});
    adc_rst_n = 1'b1;
    tick(2);

    // Fixed frame, tready high then toggling; a start mid-run must be ignored
    for (int pass = 0; pass < 2; pass++) begin
      rdy_mode = pass;
      start_run(3);
      for (int i = 0; i < 3; i++) begin
        send_frame(64'h4444_3333_2222_1111);
        if (i == 0) begin
          sample_len = 1; sample_start = 1'b1; tick(); sample_start = 1'b0; tick(14);
        end else tick(15);
      end
      finish_run(pass == 0 ? "fixed_rdy" : "fixed_toggle");
    end

    // Second strobe 4 cycles after the first is dropped
    rdy_mode = 0;
    start_run(2);
    send_frame({$urandom, $urandom}); tick(3);
    send_frame({$urandom, $urandom}); tick(3);
    send_frame({$urandom, $urandom});
    chk_eq("drop_overflow_set", overflow, 1'b1);
    finish_run("drop");

    // Backpressure long enough to fill the FIFO and stall the serialiser
    rdy_mode = 3;
    tick();
    start_run(70);
    b0 = beats_seen;
    for (int i = 0; i < 65; i++) begin
      send_frame({$urandom, $urandom});
      tick(7);
    end
    tick(80);
    chk_eq("stall_no_pops", beats_seen - b0, 0);
    chk_eq("stall_tvalid", m_axis_tvalid, 1'b1);
    rdy_mode = 0;
    tick(30);
    for (int i = 0; i < 5; i++) begin
      send_frame({$urandom, $urandom});
      tick(7);
    end
    finish_run("stall");

    // Zero-length start is ignored
    start_run(0);
    tick(3);
    chk_eq("len0_sample_en", sample_en, 1'b0);
    chk_eq("len0_busy", busy, 1'b0);

    // Reset in the middle of a capture
    start_run(5);
    send_frame({$urandom, $urandom}); tick(7);
    send_frame({$urandom, $urandom}); tick(3);
    adc_rst_n = 1'b0;
    #1;
    chk_eq("midrst_sample_en", sample_en, 1'b0);
    chk_eq("midrst_busy", busy, 1'b0);
    chk_eq("midrst_done", done, 1'b0);
    chk_eq("midrst_overflow", overflow, 1'b0);
    chk_eq("midrst_tvalid", m_axis_tvalid, 1'b0);
    chk_eq("midrst_tlast", m_axis_tlast, 1'b0);
    chk_eq("midrst_tdata", m_axis_tdata, 0);
    exp_q.delete();
    tick(2);
    adc_rst_n = 1'b1;
    tick(3);
    chk_eq("postrst_tvalid", m_axis_tvalid, 1'b0);
    chk_eq("postrst_busy", busy, 1'b0);

    // Randomised captures: random lengths, strobe spacing, data and tready
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      start_run($urandom_range(1, 5));
      while (run_acc < run_len) begin
        send_frame({$urandom, $urandom});
        tick($urandom_range(0, 19));
      end
      send_frame({$urandom, $urandom});
      finish_run("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
